fifo_wr_arb: RTL

FIFO_WR_ARB -- requirements
Module: fifo_wr_arb

---
 rtl/fifo_wr_arb_if.sv | 28 ++
 rtl/fifo_wr_arb.sv | 92 +++++++++
 2 files changed

// File: rtl/fifo_wr_arb_if.sv
// Requester-side and FIFO-write-side signals of the write-port arbiter.
// The master modport is the arbiter; the slave modport is the requesters and FIFO together.
interface fifo_wr_arb_if #(
  parameter int NREQ  = 4,
  parameter int DSIZE = 8
);
  localparam int IDW = $clog2(NREQ);

  logic [NREQ-1:0]       req_valid;
  logic [NREQ*DSIZE-1:0] req_data;
  logic [NREQ-1:0]       req_last;
  logic [NREQ-1:0]       req_ready;
  logic                  wfull;
  logic                  winc;
  logic [DSIZE-1:0]      wdata;
  logic                  gnt_valid;
  logic [IDW-1:0]        gnt_id;

  modport master (
    input  req_valid, req_data, req_last, wfull,
    output req_ready, winc, wdata, gnt_valid, gnt_id
  );

  modport slave (
    output req_valid, req_data, req_last, wfull,
    input  req_ready, winc, wdata, gnt_valid, gnt_id
  );
endinterface

// File: rtl/fifo_wr_arb.sv
// Round-robin burst arbiter that gives NREQ requesters exclusive use of a FIFO write port.
// A grant lasts until the granted requester's last beat or MAXBEATS beats, then one IDLE cycle follows.
module fifo_wr_arb #(
  parameter int NREQ     = 4,
  parameter int DSIZE    = 8,
  parameter int MAXBEATS = 16
) (
  input  logic          wclk,
  input  logic          wrst,
  fifo_wr_arb_if.master bus
);
  localparam int IDW = $clog2(NREQ);
  localparam int BW  = (MAXBEATS > 1) ? $clog2(MAXBEATS) : 1;

  typedef enum logic {IDLE, BURST} state_t;

  state_t         state_q, state_d;
  logic [IDW-1:0] gnt_id_q, gnt_id_d;
  logic [IDW-1:0] last_id_q, last_id_d;
  logic [BW-1:0]  beat_q, beat_d;

  logic           pick_found;
  logic [IDW-1:0] pick_id;
  logic [IDW-1:0] idx;
  logic           port_open;
  logic           winc_w;
  logic           release_w;

  // Descending scan so the smallest offset from last_id wins; IDW-bit adds wrap mod NREQ.
  always_comb begin
    pick_found = 1'b0;
    pick_id    = '0;
    idx        = '0;
    for (int k = NREQ; k >= 1; k--) begin
      idx = last_id_q + IDW'(k);
      if (bus.req_valid[idx]) begin
        pick_found = 1'b1;
        pick_id    = idx;
      end
    end
  end

  assign port_open = (state_q == BURST) && !bus.wfull;
  assign winc_w    = port_open && bus.req_valid[gnt_id_q];
  assign release_w = winc_w && (bus.req_last[gnt_id_q] || (beat_q == BW'(MAXBEATS - 1)));

  always_comb begin
    state_d   = state_q;
    gnt_id_d  = gnt_id_q;
    last_id_d = last_id_q;
    beat_d    = beat_q;
    case (state_q)
      IDLE: begin
        if (pick_found) begin
          state_d  = BURST;
          gnt_id_d = pick_id;
          beat_d   = '0;
        end
      end
      BURST: begin
        if (release_w) begin
          state_d   = IDLE;
          last_id_d = gnt_id_q;
        end else if (winc_w) begin
          beat_d = beat_q + BW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge wclk or posedge wrst) begin
    if (wrst) begin
      state_q   <= IDLE;
      gnt_id_q  <= '0;
      last_id_q <= IDW'(NREQ - 1);
      beat_q    <= '0;
    end else begin
      state_q   <= state_d;
      gnt_id_q  <= gnt_id_d;
      last_id_q <= last_id_d;
      beat_q    <= beat_d;
    end
  end

  assign bus.gnt_valid = (state_q == BURST);
  assign bus.gnt_id    = gnt_id_q;
  assign bus.req_ready = port_open ? (NREQ'(1) << gnt_id_q) : '0;
  assign bus.winc      = winc_w;
  assign bus.wdata     = (state_q == BURST) ? bus.req_data[gnt_id_q*DSIZE +: DSIZE] : '0;

endmodule
